// File: rtl/program_counter_stk_pkg.sv
// program_counter_stk_pkg: shared defaults, action encoding and width helper for the program counter
package program_counter_stk_pkg;
  localparam int ADDR_W_DEF = 8;
  localparam int STK_DEPTH_DEF = 4;
  localparam int RESET_ADDR_DEF = 0;
  typedef enum logic [2:0] {OP_INC, OP_JMP, OP_CALL, OP_RET, OP_HOLD} op_t;
  function automatic int clog2(input int n);
    int r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
endpackage

// File: rtl/program_counter_stk_call_stack.sv
// call_stack: circular return-address stack with depth count and sticky over/underflow flags
module call_stack
  import program_counter_stk_pkg::*;
#(
  parameter int W = ADDR_W_DEF,
  parameter int D = STK_DEPTH_DEF,
  localparam int PW = clog2(D)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  din,
  output logic [W-1:0]  dout,
  output logic [PW:0]   depth,
  output logic          ovf,
  output logic          unf
);
  logic [W-1:0] mem [D];
  logic [PW-1:0] ptr;
  logic full, empty;
  assign full = depth == (PW+1)'(D);
  assign empty = depth == '0;
  assign dout = mem[ptr - PW'(1)];
  always_ff @(posedge clk)
    if (!rst && push) mem[ptr] <= din;
  // a full push wraps the pointer onto the oldest entry and leaves depth saturated
  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
      depth <= '0;
      ovf <= 1'b0;
      unf <= 1'b0;
    end else if (push) begin
      ptr <= ptr + PW'(1);
      depth <= full ? depth : depth + 1'b1;
      ovf <= ovf | full;
    end else if (pop) begin
      ptr <= empty ? ptr : ptr - PW'(1);
      depth <= empty ? depth : depth - 1'b1;
      unf <= unf | empty;
    end
  end
endmodule

// File: rtl/program_counter_stk.sv
// program_counter_stk: instruction address register with hold, jump and stacked call/return
module program_counter_stk
  import program_counter_stk_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int STK_DEPTH = STK_DEPTH_DEF,
  parameter int unsigned RESET_ADDR = RESET_ADDR_DEF
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      HOLD,
  input  logic                      JMP,
  input  logic                      CALL,
  input  logic                      RET,
  input  logic [ADDR_W-1:0]         TARGET,
  output logic [ADDR_W-1:0]         Addr,
  output logic [clog2(STK_DEPTH):0] Depth,
  output logic                      OVF,
  output logic                      UNF
);
  op_t op;
  logic [ADDR_W-1:0] inc, top, next_addr;
  assign inc = Addr + 1'b1;
  always_comb begin
    op = HOLD ? OP_HOLD : RET ? OP_RET : CALL ? OP_CALL : JMP ? OP_JMP : OP_INC;
    next_addr = op == OP_HOLD ? Addr :
                op == OP_RET ? (Depth != '0 ? top : inc) :
                (op == OP_CALL || op == OP_JMP) ? TARGET : inc;
  end
  always_ff @(posedge CLK)
    Addr <= RST ? ADDR_W'(RESET_ADDR) : next_addr;
  call_stack #(.W(ADDR_W), .D(STK_DEPTH)) stk (
    .clk(CLK),
    .rst(RST),
    .push(op == OP_CALL),
    .pop(op == OP_RET),
    .din(inc),
    .dout(top),
    .depth(Depth),
    .ovf(OVF),
    .unf(UNF)
  );
endmodule
